// File: rtl/refresh_scan_ctrl_pkg.sv
// Shared sizing and types for the 4-digit display scan path.
package scan_pkg;

    localparam int unsigned NDIG = 4;
    localparam int unsigned DIGW = 4;
    localparam int unsigned IDXW = 2;
    localparam int unsigned VALW = NDIG * DIGW;

    typedef logic [IDXW-1:0] digit_idx_t;
    typedef logic [DIGW-1:0] nibble_t;
    typedef logic [VALW-1:0] value_t;

endpackage

// File: rtl/refresh_scan_ctrl_tick_gen.sv
// Prescaler for the digit-refresh slot; tick marks the last cycle of a slot.
module tick_gen #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (en) begin
            if (presc == LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + CW'(1);
            end
        end
    end

    assign tick = en && (presc == LAST);

endmodule

// File: rtl/refresh_scan_ctrl.sv
// Display scan controller: refresh counter, frame-synchronous value commit,
// active-digit nibble mux and leading-zero blanking.
module refresh_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            load,
    input  logic [VALW-1:0] value_in,
    input  logic            blank_lz,
    output logic [IDXW-1:0] refreshcounter,
    output logic [DIGW-1:0] digit_o,
    output logic            blank_o,
    output logic            tick_o,
    output logic            frame_o,
    output logic            pending_o
);

    logic   tick;
    value_t pend;
    value_t disp;
    logic   pending;
    logic   upper_nz;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (tick)
    );

    assign tick_o  = tick;
    assign frame_o = tick && (refreshcounter == digit_idx_t'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refreshcounter <= '0;
        end else if (tick) begin
            refreshcounter <= refreshcounter + digit_idx_t'(1);
        end
    end

    // A load coinciding with the frame boundary bypasses the buffer so it
    // is shown in the very next frame rather than one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else if (load && !frame_o) begin
            pend    <= value_in;
            pending <= 1'b1;
        end else if (load && frame_o) begin
            disp    <= value_in;
            pending <= 1'b0;
        end else if (frame_o && pending) begin
            disp    <= pend;
            pending <= 1'b0;
        end
    end

    assign pending_o = pending;

    always_comb begin
        digit_o  = '0;
        upper_nz = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (refreshcounter == digit_idx_t'(i)) begin
                digit_o = disp[i*DIGW +: DIGW];
            end
            if (digit_idx_t'(i) >= refreshcounter && disp[i*DIGW +: DIGW] != '0) begin
                upper_nz = 1'b1;
            end
        end
    end

    assign blank_o = blank_lz && (refreshcounter != '0) && !upper_nz;

endmodule

// File: tb/tb_refresh_scan_ctrl.sv
// Self-checking bench for refresh_scan_ctrl against a cycle-level reference model.
module tb_refresh_scan_ctrl;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic        blank_lz = 1'b0;
    logic [1:0]  refreshcounter;
    logic [3:0]  digit_o;
    logic        blank_o;
    logic        tick_o;
    logic        frame_o;
    logic        pending_o;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int          m_presc = 0;
    int          m_rc = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pending = 0;

    refresh_scan_ctrl #(.PRESCALE(P)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .load          (load),
        .value_in      (value_in),
        .blank_lz      (blank_lz),
        .refreshcounter(refreshcounter),
        .digit_o       (digit_o),
        .blank_o       (blank_o),
        .tick_o        (tick_o),
        .frame_o       (frame_o),
        .pending_o     (pending_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_tick();
        return en && (m_presc == P - 1);
    endfunction

    function automatic bit m_frame();
        return m_tick() && (m_rc == 3);
    endfunction

    function automatic logic [3:0] m_digit();
        return 4'((m_disp >> (4 * m_rc)) & 16'hF);
    endfunction

    function automatic bit m_blank();
        return blank_lz && (m_rc != 0) && ((m_disp >> (4 * m_rc)) == 16'h0);
    endfunction

    task automatic check_all();
        check("refreshcounter", 16'(refreshcounter), 16'(m_rc));
        check("digit_o", 16'(digit_o), 16'(m_digit()));
        check("blank_o", 16'(blank_o), 16'(m_blank()));
        check("tick_o", 16'(tick_o), 16'(m_tick()));
        check("frame_o", 16'(frame_o), 16'(m_frame()));
        check("pending_o", 16'(pending_o), 16'(m_pending));
    endtask

    // one clock: advance the model with the pre-edge inputs, then compare
    task automatic step();
        bit t, f;
        t = m_tick();
        f = m_frame();
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (load && !f) begin
                m_pend = value_in;
                m_pending = 1;
            end else if (load && f) begin
                m_disp = value_in;
                m_pending = 0;
            end else if (f && m_pending) begin
                m_disp = m_pend;
                m_pending = 0;
            end
            if (en) m_presc = (m_presc + 1) % P;
            if (t) m_rc = (m_rc + 1) % 4;
        end
        check_all();
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_rc = 0;
        m_disp = '0;
        m_pend = '0;
        m_pending = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        value_in = v;
        step();
        load = 1'b0;
    endtask

    task automatic run_to_rc(input int rc, input string tag);
        int k;
        for (k = 0; k < 64 && m_rc != rc; k++) step();
        check(tag, 16'(refreshcounter), 16'(rc));
    endtask

    task automatic run_to_frame(input string tag);
        int k;
        for (k = 0; k < 64 && !m_frame(); k++) step();
        check(tag, 16'(frame_o), 16'd1);
    endtask

    initial begin
        int frames;

        // initial reset
        #12;
        model_reset();
        check_all();
        rst_n = 1'b1;
        en = 1'b1;

        // 1: asynchronous reset with refreshcounter=2 and a value pending
        run_to_rc(2, "reach_rc2");
        do_load(16'hBEEF);
        check("pend_before_rst", 16'(pending_o), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_rc", 16'(refreshcounter), 16'd0);
        check("rst_digit", 16'(digit_o), 16'd0);
        check("rst_blank", 16'(blank_o), 16'd0);
        check("rst_tick", 16'(tick_o), 16'd0);
        check("rst_frame", 16'(frame_o), 16'd0);
        check("rst_pending", 16'(pending_o), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: free-running scan, two frames in 32 clocks
        frames = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (frame_o) frames++;
        end
        check("frames_per_32", 16'(frames), 16'd2);

        // 3: buffered load committed at the frame boundary
        run_to_rc(1, "reach_rc1");
        do_load(16'h1234);
        check("pend_set", 16'(pending_o), 16'd1);
        check("digit_held", 16'(digit_o), 16'd0);
        run_to_frame("frame_for_1234");
        step();
        check("commit_digit0", 16'(digit_o), 16'h4);
        check("commit_pending", 16'(pending_o), 16'd0);
        for (int i = 0; i < 16; i++) step();

        // 4: load on the frame cycle bypasses the buffer
        run_to_frame("frame_for_abcd");
        do_load(16'hABCD);
        check("bypass_rc", 16'(refreshcounter), 16'd0);
        check("bypass_digit", 16'(digit_o), 16'hD);
        check("bypass_pending", 16'(pending_o), 16'd0);

        // 5: last load in a frame wins
        run_to_rc(1, "reach_rc1_b");
        do_load(16'h1111);
        step();
        do_load(16'h2222);
        run_to_frame("frame_for_2222");
        for (int i = 0; i < 16; i++) begin
            step();
            check("last_wins", 16'(digit_o), 16'h2);
        end

        // 6: leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0050);
        run_to_frame("frame_for_0050");
        for (int i = 0; i < 16; i++) step();
        run_to_rc(2, "reach_rc2_b");
        check("blank_d2", 16'(blank_o), 16'd1);
        run_to_rc(1, "reach_rc1_c");
        check("blank_d1", 16'(blank_o), 16'd0);
        do_load(16'h0000);
        run_to_frame("frame_for_0000");
        for (int i = 0; i < 16; i++) step();
        blank_lz = 1'b0;
        for (int i = 0; i < 16; i++) step();

        // en=0 freezes scan, loads still buffer
        en = 1'b0;
        do_load(16'h9876);
        for (int i = 0; i < 12; i++) step();
        check("frozen_pending", 16'(pending_o), 16'd1);
        en = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 9) == 0);
            blank_lz = 1'($urandom_range(0, 1));
            value_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value_in = value_in & 16'h00FF;
            step();
        end
        load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
